// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop and lap/reset commands gate a BCD mm:ss.cc
// counter advanced by the 10 ms tick, with a lap latch that freezes the display.
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE10,
  input  logic        SS,
  input  logic        LR,
  output logic [23:0] DISP,
  output logic        RUNNING,
  output logic        LAPHOLD,
  output logic        OVF
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  localparam logic [3:0] MAXM1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAXM0 = 4'(MAX_MIN % 10);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] lap_q, lap_d;
  logic        ovf_q, ovf_d;
  logic [23:0] inc_val;
  logic        inc_wrap;

  // Returns {wrap, next}; digit order {m1,m0,s1,s0,c1,c0}.
  function automatic logic [24:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    logic        w;
    r = c;
    w = 1'b0;
    if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) r[7:4] = c[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) r[11:8] = c[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (c[15:12] != 4'd5) r[15:12] = c[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (c[23:20] == MAXM1 && c[19:16] == MAXM0) begin
              r = 24'd0;
              w = 1'b1;
            end else if (c[19:16] != 4'd9) begin
              r[19:16] = c[19:16] + 4'd1;
            end else begin
              r[19:16] = 4'd0;
              r[23:20] = c[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return {w, r};
  endfunction

  always_comb begin
    {inc_wrap, inc_val} = bcd_inc(cnt_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = 1'b0;
    // Counting depends on the pre-edge state, independent of the transition taken.
    if (CE10 && (state_q == RUN || state_q == LAP)) begin
      cnt_d = inc_val;
      ovf_d = inc_wrap;
    end
    case (state_q)
      IDLE:  if (SS) state_d = RUN;
      RUN: begin
        if (SS) state_d = PAUSE;
        else if (LR) begin
          state_d = LAP;
          lap_d   = cnt_q;
        end
      end
      LAP: begin
        if (SS) state_d = PAUSE;
        else if (LR) state_d = RUN;
      end
      PAUSE: begin
        if (SS) state_d = RUN;
        else if (LR) begin
          state_d = IDLE;
          cnt_d   = 24'd0;
          lap_d   = 24'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 24'd0;
      lap_q   <= 24'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DISP    = (state_q == LAP) ? lap_q : cnt_q;
  assign RUNNING = (state_q == RUN) || (state_q == LAP);
  assign LAPHOLD = (state_q == LAP);
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl (MAX_MIN=0 so the minute wrap is reachable quickly).
module tb_stopwatch_ctrl;

  logic        CLK;
  logic        RST;
  logic        CE10;
  logic        SS;
  logic        LR;
  logic [23:0] DISP;
  logic        RUNNING;
  logic        LAPHOLD;
  logic        OVF;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [26:0] v;   // {DISP, RUNNING, LAPHOLD, OVF}
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [26:0] got;

  stopwatch_ctrl #(.MAX_MIN(0)) dut (
    .CLK(CLK), .RST(RST), .CE10(CE10), .SS(SS), .LR(LR),
    .DISP(DISP), .RUNNING(RUNNING), .LAPHOLD(LAPHOLD), .OVF(OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string name, input logic [23:0] disp,
                      input logic run, input logic lap, input logic ovf);
    exp_t x;
    x.name = name;
    x.v    = {disp, run, lap, ovf};
    sb.push_back(x);
  endtask

  task automatic drive(input logic ss, input logic lr, input logic ce);
    SS = ss; LR = lr; CE10 = ce;
    cycle();
    SS = 1'b0; LR = 1'b0; CE10 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      cycle();
    end
  endtask

  task automatic test_reset();
    int ovf_seen;
    ovf_seen = 0;
    RST = 1'b1;
    CE10 = 1'b1;
    SS = 1'b1;
    cycle();
    CE10 = 1'b0;
    SS = 1'b0;
    cycle();
    push("reset_state", 24'h000000, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      CE10 = ~CE10;
      if (i == 4) LR = 1'b1;
      cycle();
      LR = 1'b0;
      if (OVF !== 1'b0) ovf_seen++;
    end
    CE10 = 1'b0;
    push("reset_idle", 24'h000000, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    checks++;
    if (ovf_seen !== 0) begin failures++; $display("FAIL reset_ovf got=%0d expected=0 pulses", ovf_seen); end
  endtask

  task automatic test_run();
    drive(1'b1, 1'b0, 1'b1);   // tick on IDLE->RUN edge is not counted
    ticks(150);
    push("run_150", 24'h000150, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b1, 1'b0, 1'b0);
    ticks(20);
    push("pause_hold", 24'h000150, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b1, 1'b0, 1'b1);
    push("resume_nocount", 24'h000150, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b1, 1'b0, 1'b1);
    push("stop_counts", 24'h000151, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b1, 1'b0);
    push("pause_clear", 24'h000000, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
  endtask

  task automatic test_lap();
    drive(1'b1, 1'b0, 1'b0);
    ticks(25);
    drive(1'b0, 1'b1, 1'b0);
    ticks(30);
    push("lap_frozen", 24'h000025, 1'b1, 1'b1, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b1, 1'b0);
    push("lap_release", 24'h000055, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b1, 1'b1);   // latch takes the pre-increment count
    push("lap_with_tick", 24'h000055, 1'b1, 1'b1, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    ticks(1);
    drive(1'b1, 1'b0, 1'b0);
    push("lap_to_pause", 24'h000057, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0);
    ticks(5999);
    push("wrap_max", 24'h005999, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b0, 1'b1);
    push("wrap_ovf", 24'h000000, 1'b1, 1'b0, 1'b1);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    cycle();
    push("wrap_ovf_drop", 24'h000000, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    ticks(1);
    push("wrap_continue", 24'h000001, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b0, 1'b0);
    ticks(40);
    drive(1'b1, 1'b1, 1'b0);
    push("prio_ss_wins", 24'h000040, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b1, 1'b0);
    push("prio_clear", 24'h000000, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
  endtask

  task automatic test_midrun_reset();
    drive(1'b1, 1'b0, 1'b0);
    ticks(317);
    push("mid_317", 24'h000317, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    RST = 1'b0;
    push("mid_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b0, 1'b1, 1'b0);   // LR ignored in IDLE
    ticks(2);
    push("mid_idle", 24'h000000, 1'b0, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
    drive(1'b1, 1'b0, 1'b0);
    ticks(1);
    push("first_tick", 24'h000001, 1'b1, 1'b0, 1'b0);
    got = {DISP, RUNNING, LAPHOLD, OVF};
    e = sb.pop_front(); checks++;
    if (got !== e.v) begin failures++; $display("FAIL %s got=%h expected=%h", e.name, got, e.v); end
  endtask

  initial begin
    RST = 1'b1; CE10 = 1'b0; SS = 1'b0; LR = 1'b0;
    test_reset();
    test_run();
    test_lap();
    test_wrap();
    test_priority();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
